// File: rtl/bcm_readout_sequencer_pkg.sv
// Shared definitions for the bunch-current-monitor readout path: sequencer
// states, control-word bit positions and readout address-word layout.
package bcm_readout_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACQ,
    STROBE,
    SETTLE,
    PUSH
  } seqState_t;

  localparam int CTRL_START_BIT   = 31;
  localparam int CTRL_ABORT_BIT   = 30;
  localparam int ACQ_ACTIVE_BIT   = 31;
  localparam int ADDR_SAMPLE_LSB  = 0;
  localparam int ADDR_CHANNEL_LSB = 24;

  // Degenerate parameter sets can produce zero-width fields; keep them at one bit.
  function automatic int widthMin1(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  // The row field sits directly above the sample field, so its offset is the sample width.
  function automatic logic [31:0] packAddrWord(input logic [31:0] channel,
                                               input logic [31:0] row,
                                               input logic [31:0] sample,
                                               input int          rowLsb);
    return (channel << ADDR_CHANNEL_LSB) | (row << rowLsb) | (sample << ADDR_SAMPLE_LSB);
  endfunction

endpackage

// File: rtl/bcm_readout_sequencer_index_counter.sv
// Nested sample/row/channel counters for the readout walk, with a flag that
// marks the final word of the acquisition.
module bcm_readout_index_counter #(
  parameter int CHANNEL_COUNT         = 2,
  parameter int AXI_SAMPLES_PER_CLOCK = 4,
  parameter int DAW                   = 4,
  parameter int SIW                   = 3,
  parameter int CIW                   = 1
) (
  input  logic           sysClk,
  input  logic           sysReset,
  input  logic           clear,
  input  logic           advance,
  input  logic [DAW-1:0] rowLast,
  output logic [SIW-1:0] sampleNext,
  output logic [DAW-1:0] rowNext,
  output logic [CIW-1:0] channelNext,
  output logic           isLast
);

  logic [SIW-1:0] sampleReg;
  logic [DAW-1:0] rowReg;
  logic [CIW-1:0] channelReg;
  logic           sampleWrap;
  logic           rowWrap;

  assign sampleWrap = (sampleReg == SIW'(AXI_SAMPLES_PER_CLOCK - 1));
  assign rowWrap    = (rowReg == rowLast);
  assign isLast     = sampleWrap && rowWrap && (channelReg == CIW'(CHANNEL_COUNT - 1));

  // Next values are exported so the address word can be loaded on the same edge the indices move.
  always_comb begin
    sampleNext  = sampleReg;
    rowNext     = rowReg;
    channelNext = channelReg;
    if (clear) begin
      sampleNext  = '0;
      rowNext     = '0;
      channelNext = '0;
    end else if (advance) begin
      if (sampleWrap) begin
        sampleNext = '0;
        if (rowWrap) begin
          rowNext     = '0;
          channelNext = isLast ? '0 : channelReg + 1'b1;
        end else begin
          rowNext = rowReg + 1'b1;
        end
      end else begin
        sampleNext = sampleReg + 1'b1;
      end
    end
  end

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      sampleReg  <= '0;
      rowReg     <= '0;
      channelReg <= '0;
    end else begin
      sampleReg  <= sampleNext;
      rowReg     <= rowNext;
      channelReg <= channelNext;
    end
  end

endmodule

// File: rtl/bcm_readout_sequencer.sv
// Autonomous acquisition-buffer reader: strobes each readout address, waits a
// settle delay, captures the readout value and streams it out for DMA.
module bcm_readout_sequencer
  import bcm_readout_sequencer_pkg::*;
#(
  parameter int CHANNEL_COUNT         = 2,
  parameter int SAMPLE_CAPACITY       = 64,
  parameter int AXI_SAMPLES_PER_CLOCK = 4,
  parameter int SETTLE_CYCLES         = 8
) (
  input  logic        sysClk,
  input  logic        sysReset,
  input  logic        sysCsrStrobe,
  input  logic [31:0] GPIO_OUT,
  output logic [31:0] sysStatusReg,
  input  logic [31:0] acqStatus,
  output logic        sysAddrStrobe,
  output logic [31:0] sysAddrWord,
  input  logic [31:0] sysReadoutReg,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast
);

  localparam int DAW = widthMin1($clog2(SAMPLE_CAPACITY / AXI_SAMPLES_PER_CLOCK));
  localparam int SIW = widthMin1($clog2(AXI_SAMPLES_PER_CLOCK + 1));
  localparam int CIW = widthMin1($clog2(CHANNEL_COUNT));
  localparam int SCW = widthMin1($clog2(SETTLE_CYCLES));

  seqState_t      stateReg, stateNext;
  logic           startReq, abortReq, abortRun;
  logic           clearIdx, loadSettle, capture, accept;
  logic [SCW-1:0] settleCountReg;
  logic [DAW-1:0] rowLastReg;
  logic [23:0]    wordCountReg;
  logic           busyReg, waitAcqReg, abortedReg;
  logic           addrStrobeReg, mValidReg, mLastReg;
  logic [31:0]    addrWordReg, mDataReg;
  logic [SIW-1:0] sampleNext;
  logic [DAW-1:0] rowNext;
  logic [CIW-1:0] channelNext;
  logic           isLast;
  logic           unusedBits;

  assign unusedBits = &{1'b0, GPIO_OUT[29:0], acqStatus[30:DAW]};

  // Abort dominates a simultaneous start, even in IDLE where abort itself does nothing.
  assign abortReq = sysCsrStrobe && GPIO_OUT[CTRL_ABORT_BIT];
  assign startReq = sysCsrStrobe && GPIO_OUT[CTRL_START_BIT] && !abortReq;
  assign abortRun = abortReq && (stateReg != IDLE);

  always_comb begin
    stateNext  = stateReg;
    clearIdx   = 1'b0;
    loadSettle = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    case (stateReg)
      IDLE: begin
        if (startReq) begin
          clearIdx  = 1'b1;
          stateNext = WAIT_ACQ;
        end
      end
      WAIT_ACQ: begin
        if (!acqStatus[ACQ_ACTIVE_BIT]) stateNext = STROBE;
      end
      STROBE: begin
        loadSettle = 1'b1;
        stateNext  = SETTLE;
      end
      SETTLE: begin
        if (settleCountReg == '0) begin
          capture   = 1'b1;
          stateNext = PUSH;
        end
      end
      PUSH: begin
        if (mValidReg && m_tready) begin
          accept    = 1'b1;
          stateNext = mLastReg ? IDLE : STROBE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (abortRun) begin
      stateNext  = IDLE;
      loadSettle = 1'b0;
      capture    = 1'b0;
      accept     = 1'b0;
    end
  end

  bcm_readout_index_counter #(
    .CHANNEL_COUNT        (CHANNEL_COUNT),
    .AXI_SAMPLES_PER_CLOCK(AXI_SAMPLES_PER_CLOCK),
    .DAW                  (DAW),
    .SIW                  (SIW),
    .CIW                  (CIW)
  ) indexCounter (
    .sysClk     (sysClk),
    .sysReset   (sysReset),
    .clear      (clearIdx),
    .advance    (accept),
    .rowLast    (rowLastReg),
    .sampleNext (sampleNext),
    .rowNext    (rowNext),
    .channelNext(channelNext),
    .isLast     (isLast)
  );

  always_ff @(posedge sysClk or posedge sysReset) begin
    if (sysReset) begin
      stateReg       <= IDLE;
      settleCountReg <= '0;
      rowLastReg     <= '0;
      wordCountReg   <= '0;
      busyReg        <= 1'b0;
      waitAcqReg     <= 1'b0;
      abortedReg     <= 1'b0;
      addrStrobeReg  <= 1'b0;
      addrWordReg    <= '0;
      mDataReg       <= '0;
      mValidReg      <= 1'b0;
      mLastReg       <= 1'b0;
    end else begin
      stateReg      <= stateNext;
      busyReg       <= (stateNext != IDLE);
      waitAcqReg    <= (stateNext == WAIT_ACQ);
      addrStrobeReg <= (stateNext == STROBE);
      if (stateNext == STROBE) begin
        addrWordReg <= packAddrWord(32'(channelNext), 32'(rowNext), 32'(sampleNext), SIW);
      end
      if (clearIdx) begin
        rowLastReg   <= acqStatus[DAW-1:0];
        wordCountReg <= '0;
        abortedReg   <= 1'b0;
      end
      if (abortRun) abortedReg <= 1'b1;
      if (loadSettle) begin
        settleCountReg <= SCW'(SETTLE_CYCLES - 1);
      end else if (stateReg == SETTLE && settleCountReg != '0) begin
        settleCountReg <= settleCountReg - 1'b1;
      end
      // Output word stays frozen while stalled; only capture, accept or abort touch it.
      if (capture) begin
        mDataReg  <= sysReadoutReg;
        mValidReg <= 1'b1;
        mLastReg  <= isLast;
      end else if (accept || abortRun) begin
        mValidReg <= 1'b0;
        mLastReg  <= 1'b0;
      end
      if (accept) wordCountReg <= wordCountReg + 1'b1;
    end
  end

  assign sysStatusReg  = {busyReg, waitAcqReg, abortedReg, 5'b0, wordCountReg};
  assign sysAddrStrobe = addrStrobeReg;
  assign sysAddrWord   = addrWordReg;
  assign m_tdata       = mDataReg;
  assign m_tvalid      = mValidReg;
  assign m_tlast       = mLastReg;

endmodule

// File: tb/tb_bcm_readout_sequencer.sv
// Self-checking bench for bcm_readout_sequencer: table-driven runs, randomized
// back-pressure and salt, plus hand-written abort/reset/ignored-start sequences.
module tb_bcm_readout_sequencer;

  localparam int CH      = 2;
  localparam int SPC     = 4;
  localparam int CAP     = 64;
  localparam int S       = 8;
  localparam int ROW_LSB = $clog2(SPC + 1);
  localparam int GUARD   = 20000;
  localparam logic [31:0] CTRL_START = 32'h8000_0000;
  localparam logic [31:0] CTRL_ABORT = 32'h4000_0000;

  typedef struct {
    int unsigned r;
    int          readyPct;
    int          acqHold;
    int          abortAfter;
    int          restartAt;
    bit          useSalt;
    int          expWords;
    bit          expAborted;
  } vec_t;

  logic        sysClk = 1'b0;
  logic        sysReset = 1'b1;
  logic        sysCsrStrobe = 1'b0;
  logic [31:0] GPIO_OUT = '0;
  logic [31:0] sysStatusReg;
  logic [31:0] acqStatus = '0;
  logic        sysAddrStrobe;
  logic [31:0] sysAddrWord;
  logic [31:0] sysReadoutReg;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        m_tlast;

  int          checkCount = 0;
  int          passCount = 0;
  int          cycleCount = 0;
  int          strobeSeen = 0;
  logic [31:0] salt = '0;
  logic [31:0] lastAddr = '0;
  bit          stallCheckOn = 1'b0;
  bit          prevStall = 1'b0;
  logic [31:0] prevData = '0;
  logic        prevLast = 1'b0;
  logic [31:0] recvData[$];
  bit          recvLast[$];
  int          recvCycle[$];

  always #5 sysClk = ~sysClk;

  bcm_readout_sequencer #(
    .CHANNEL_COUNT        (CH),
    .SAMPLE_CAPACITY      (CAP),
    .AXI_SAMPLES_PER_CLOCK(SPC),
    .SETTLE_CYCLES        (S)
  ) dut (
    .sysClk       (sysClk),
    .sysReset     (sysReset),
    .sysCsrStrobe (sysCsrStrobe),
    .GPIO_OUT     (GPIO_OUT),
    .sysStatusReg (sysStatusReg),
    .acqStatus    (acqStatus),
    .sysAddrStrobe(sysAddrStrobe),
    .sysAddrWord  (sysAddrWord),
    .sysReadoutReg(sysReadoutReg),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tlast      (m_tlast)
  );

  // Acquisition buffer stand-in: the readout register reflects the last strobed address.
  always @(posedge sysClk) if (sysAddrStrobe) lastAddr <= sysAddrWord;
  assign sysReadoutReg = lastAddr ^ salt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic csrWrite(input logic [31:0] w);
    sysCsrStrobe = 1'b1;
    GPIO_OUT     = w;
    tick();
    sysCsrStrobe = 1'b0;
    GPIO_OUT     = '0;
  endtask

  // Expected address of the k-th word: sample fastest, then row 0..r, then channel.
  function automatic logic [31:0] expAddr(input int k, input int r);
    int perCh, ch, rem;
    perCh = (r + 1) * SPC;
    ch    = k / perCh;
    rem   = k % perCh;
    return (32'(ch) << 24) | (32'(rem / SPC) << ROW_LSB) | 32'(rem % SPC);
  endfunction

  always @(negedge sysClk) begin
    cycleCount++;
    if (sysAddrStrobe) strobeSeen++;
    if (stallCheckOn && prevStall)
      check("stall_hold", {30'b0, m_tvalid, m_tlast, m_tdata}, {30'b0, 1'b1, prevLast, prevData});
    prevStall = stallCheckOn && m_tvalid && !m_tready;
    prevData  = m_tdata;
    prevLast  = m_tlast;
    if (m_tvalid && m_tready) begin
      recvData.push_back(m_tdata);
      recvLast.push_back(m_tlast);
      recvCycle.push_back(cycleCount);
      $display("word %0d data=%08h last=%0d cycle=%0d", recvData.size(), m_tdata, m_tlast, cycleCount);
    end
  end

  task automatic runVector(input vec_t v);
    int  guard, n;
    bit  restarted;
    n         = CH * (int'(v.r) + 1) * SPC;
    salt      = v.useSalt ? $urandom : 32'h0;
    restarted = 1'b0;
    recvData.delete();
    recvLast.delete();
    recvCycle.delete();
    stallCheckOn = 1'b1;
    m_tready     = 1'b0;
    acqStatus    = 32'(v.r);
    acqStatus[31] = (v.acqHold > 0);
    csrWrite(CTRL_START);
    acqStatus[3:0] = 4'($urandom);
    check("busy_after_start", 64'(sysStatusReg[31]), 64'd1);
    check("waitacq_after_start", 64'(sysStatusReg[30]), 64'd1);
    if (v.acqHold > 0) begin
      for (int i = 1; i < v.acqHold; i++) begin
        tick();
        check("acq_hold_wait", 64'({sysStatusReg[30], sysAddrStrobe}), 64'd2);
      end
      acqStatus[31] = 1'b0;
    end
    tick();
    check("first_strobe", 64'(sysAddrStrobe), 64'd1);
    check("first_addr", 64'(sysAddrWord), 64'd0);
    repeat (S) tick();
    check("tvalid_before_capture", 64'(m_tvalid), 64'd0);
    tick();
    check("tvalid_at_capture", 64'(m_tvalid), 64'd1);

    guard = 0;
    while (guard < GUARD) begin
      if (v.abortAfter >= 0 && int'(recvData.size()) == v.abortAfter) break;
      if (sysStatusReg[31] == 1'b0) break;
      if (v.restartAt >= 0 && !restarted && int'(recvData.size()) == v.restartAt) begin
        sysCsrStrobe = 1'b1;
        GPIO_OUT     = CTRL_START;
        restarted    = 1'b1;
      end
      m_tready = ($urandom_range(0, 99) < v.readyPct);
      tick();
      sysCsrStrobe = 1'b0;
      GPIO_OUT     = '0;
      guard++;
    end
    check("run_no_timeout", 64'(guard < GUARD), 64'd1);

    if (v.abortAfter >= 0) begin
      m_tready     = 1'b0;
      stallCheckOn = 1'b0;
      for (int i = 0; i < S + 4 && !m_tvalid; i++) tick();
      check("abort_word_presented", 64'(m_tvalid), 64'd1);
      csrWrite(CTRL_ABORT);
      check("abort_tvalid_cleared", 64'(m_tvalid), 64'd0);
      check("abort_busy_cleared", 64'(sysStatusReg[31]), 64'd0);
    end

    repeat (3) tick();
    check("end_busy", 64'(sysStatusReg[31]), 64'd0);
    check("end_waitacq", 64'(sysStatusReg[30]), 64'd0);
    check("end_aborted", 64'(sysStatusReg[29]), 64'(v.expAborted));
    check("end_wordcount", 64'(sysStatusReg[23:0]), 64'(v.expWords));
    check("words_received", 64'(recvData.size()), 64'(v.expWords));
    for (int k = 0; k < int'(recvData.size()) && k < v.expWords; k++) begin
      check("word_data", 64'(recvData[k]), 64'(expAddr(k, int'(v.r)) ^ salt));
      check("word_last", 64'(recvLast[k]), 64'(k == n - 1));
    end
    if (v.readyPct == 100) begin
      for (int k = 1; k < int'(recvData.size()); k++)
        check("throughput", 64'(recvCycle[k] - recvCycle[k-1]), 64'(S + 2));
    end
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    int baseStrobes, tvSeen;

    vecs[0] = '{3,  100, 0,  -1, -1, 1'b0, 32,  1'b0};
    vecs[1] = '{3,  30,  0,  -1, -1, 1'b0, 32,  1'b0};
    vecs[2] = '{3,  100, 50, -1, -1, 1'b0, 32,  1'b0};
    vecs[3] = '{3,  100, 0,  5,  -1, 1'b0, 5,   1'b1};
    vecs[4] = '{3,  60,  0,  -1, -1, 1'b1, 32,  1'b0};
    vecs[5] = '{3,  100, 0,  -1, 10, 1'b1, 32,  1'b0};
    vecs[6] = '{0,  100, 0,  -1, -1, 1'b1, 8,   1'b0};
    vecs[7] = '{15, 80,  0,  -1, -1, 1'b1, 128, 1'b0};

    repeat (3) tick();
    check("reset_strobe", 64'(sysAddrStrobe), 64'd0);
    check("reset_addr", 64'(sysAddrWord), 64'd0);
    check("reset_tvalid", 64'(m_tvalid), 64'd0);
    check("reset_tlast", 64'(m_tlast), 64'd0);
    check("reset_tdata", 64'(m_tdata), 64'd0);
    check("reset_status", 64'(sysStatusReg), 64'd0);
    sysReset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    for (int i = 0; i < 3; i++) begin
      rv.r          = $urandom_range(0, 15);
      rv.readyPct   = $urandom_range(20, 90);
      rv.acqHold    = $urandom_range(0, 1) * $urandom_range(2, 20);
      rv.abortAfter = -1;
      rv.restartAt  = -1;
      rv.useSalt    = 1'b1;
      rv.expWords   = CH * (int'(rv.r) + 1) * SPC;
      rv.expAborted = 1'b0;
      runVector(rv);
    end

    // Start and abort in the same write while idle: nothing may begin.
    baseStrobes = strobeSeen;
    csrWrite(CTRL_START | CTRL_ABORT);
    repeat (15) tick();
    check("startabort_busy", 64'(sysStatusReg[31]), 64'd0);
    check("startabort_strobes", 64'(strobeSeen - baseStrobes), 64'd0);
    check("startabort_tvalid", 64'(m_tvalid), 64'd0);

    // Reset asserted while the sequencer sits in SETTLE part-way through a run.
    salt         = '0;
    stallCheckOn = 1'b0;
    acqStatus    = 32'd3;
    m_tready     = 1'b1;
    recvData.delete();
    csrWrite(CTRL_START);
    for (int i = 0; i < 200 && recvData.size() < 3; i++) tick();
    check("reset_run_progress", 64'(recvData.size() >= 3), 64'd1);
    for (int i = 0; i < S + 4 && !sysAddrStrobe; i++) tick();
    check("reset_run_strobe", 64'(sysAddrStrobe), 64'd1);
    tick();
    tick();
    sysReset = 1'b1;
    #1;
    check("midrun_reset_strobe", 64'(sysAddrStrobe), 64'd0);
    check("midrun_reset_addr", 64'(sysAddrWord), 64'd0);
    check("midrun_reset_tvalid", 64'(m_tvalid), 64'd0);
    check("midrun_reset_tlast", 64'(m_tlast), 64'd0);
    check("midrun_reset_tdata", 64'(m_tdata), 64'd0);
    check("midrun_reset_status", 64'(sysStatusReg), 64'd0);
    tick();
    tick();
    check("midrun_reset_hold", 64'({sysStatusReg, m_tvalid, sysAddrStrobe}), 64'd0);
    sysReset = 1'b0;
    tvSeen   = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_tvalid) tvSeen++;
    end
    check("post_reset_no_tvalid", 64'(tvSeen), 64'd0);
    check("post_reset_busy", 64'(sysStatusReg[31]), 64'd0);

    rv = '{1, 100, 0, -1, -1, 1'b1, 16, 1'b0};
    runVector(rv);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
